// File: rtl/sort_pass_sequencer.sv
// Multi-pass sort sequencer: launches each pass across the lane array, gathers
// per-lane done flags into a sticky mask and guards every pass with a watchdog.
module sort_pass_sequencer #(
  parameter int NUM_LANES  = 8,
  parameter int NUM_PASSES = 8,
  parameter int PASS_W     = 3,
  parameter int TIMEOUT    = 255,
  parameter int TMR_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_LANES-1:0] lane_en,
  input  logic [NUM_LANES-1:0] lane_done,
  output logic                 lane_start,
  output logic [PASS_W-1:0]    pass_idx,
  output logic [NUM_LANES-1:0] done_mask,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_FINISH = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t               state;
  logic [NUM_LANES-1:0] en_q;
  logic [TMR_W-1:0]     timer;
  logic [NUM_LANES-1:0] wait_mask;
  logic                 all_done;
  logic                 last_pass;
  logic                 tmr_expired;

  // Mask as it would stand after this WAIT cycle; only enabled lanes may set bits.
  always_comb begin
    wait_mask   = done_mask | (lane_done & en_q);
    all_done    = &wait_mask;
    last_pass   = (pass_idx == PASS_W'(NUM_PASSES - 1));
    tmr_expired = (timer == TMR_W'(TIMEOUT - 1));
  end

  // Sequencer state, pass bookkeeping and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      en_q        <= '0;
      timer       <= '0;
      pass_idx    <= '0;
      done_mask   <= '0;
      lane_start  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      lane_start <= 1'b0;
      done       <= 1'b0;
      if (abort) begin
        state       <= S_IDLE;
        busy        <= 1'b0;
        timeout_err <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state      <= S_LAUNCH;
              pass_idx   <= '0;
              en_q       <= lane_en;
              lane_start <= 1'b1;
              busy       <= 1'b1;
            end
          end
          S_LAUNCH: begin
            // Disabled lanes are pre-set so they never hold up the pass.
            done_mask <= ~en_q;
            timer     <= '0;
            state     <= S_WAIT;
          end
          S_WAIT: begin
            done_mask <= wait_mask;
            timer     <= timer + TMR_W'(1);
            if (all_done) begin
              if (last_pass) begin
                state <= S_FINISH;
                done  <= 1'b1;
              end else begin
                state      <= S_LAUNCH;
                pass_idx   <= pass_idx + PASS_W'(1);
                lane_start <= 1'b1;
              end
            end else if (tmr_expired) begin
              state       <= S_ERROR;
              busy        <= 1'b0;
              timeout_err <= 1'b1;
            end
          end
          S_FINISH: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          S_ERROR: begin
            state <= S_ERROR;
          end
          default: begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sort_pass_sequencer.sv
// Directed self-checking bench for sort_pass_sequencer: default instance plus
// a short-watchdog instance (TIMEOUT=4) driven from the same stimulus.
module tb_sort_pass_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] lane_en = 8'h00;
  logic [7:0] lane_done = 8'h00;

  logic       ls_a, busy_a, done_a, to_a;
  logic [2:0] pidx_a;
  logic [7:0] mask_a;
  logic       ls_b, busy_b, done_b, to_b;
  logic [2:0] pidx_b;
  logic [7:0] mask_b;

  int total = 0;
  int bad = 0;
  int exp_pidx_q[$];

  sort_pass_sequencer u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .lane_en(lane_en), .lane_done(lane_done),
    .lane_start(ls_a), .pass_idx(pidx_a), .done_mask(mask_a),
    .busy(busy_a), .done(done_a), .timeout_err(to_a)
  );

  sort_pass_sequencer #(.TIMEOUT(4)) u_dut_t (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .lane_en(lane_en), .lane_done(lane_done),
    .lane_start(ls_b), .pass_idx(pidx_b), .done_mask(mask_b),
    .busy(busy_b), .done(done_b), .timeout_err(to_b)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    start = 1'b0;
    abort = 1'b1;
    lane_done = 8'h00;
    step();
    abort = 1'b0;
  endtask

  initial begin
    int exp_p;
    // Reset state
    step(); step();
    chk("rst_ls", 32'(ls_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_to", 32'(to_a), 32'd0);
    chk("rst_pidx", 32'(pidx_a), 32'd0);
    chk("rst_mask", 32'(mask_a), 32'd0);
    rst = 1'b0;
    step();

    // Full run, all lanes done every cycle
    lane_en = 8'hFF;
    lane_done = 8'hFF;
    start = 1'b1;
    for (int i = 0; i < 8; i++) exp_pidx_q.push_back(i);
    step();
    start = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      exp_p = (c - 1) / 2;
      if (exp_p > 7) exp_p = 7;
      chk($sformatf("run_ls_c%0d", c), 32'(ls_a), 32'((c % 2 == 1) && (c <= 15)));
      chk($sformatf("run_done_c%0d", c), 32'(done_a), 32'(c == 17));
      chk($sformatf("run_busy_c%0d", c), 32'(busy_a), 32'd1);
      chk($sformatf("run_pidx_c%0d", c), 32'(pidx_a), 32'(exp_p));
      if (ls_a === 1'b1) begin
        if (exp_pidx_q.size() > 0) chk("sb_pidx", 32'(pidx_a), 32'(exp_pidx_q.pop_front()));
        else chk("sb_extra_launch", 32'd1, 32'd0);
      end
      step();
    end
    chk("sb_left", 32'(exp_pidx_q.size()), 32'd0);
    chk("run_busy_c18", 32'(busy_a), 32'd0);
    chk("run_done_c18", 32'(done_a), 32'd0);
    chk("run_pidx_hold", 32'(pidx_a), 32'd7);

    // All lanes disabled: 2 cycles per pass, done at cycle 17
    clear();
    lane_en = 8'h00;
    lane_done = 8'h00;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 17; c++) step();
    chk("dis_done_c17", 32'(done_a), 32'd1);
    step();
    chk("dis_busy_c18", 32'(busy_a), 32'd0);

    // Staggered lane completion, lane_en=0F
    clear();
    lane_en = 8'h0F;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      lane_done = (c == 2) ? 8'h01 : (c == 5) ? 8'h06 : (c == 9) ? 8'h08 : 8'h00;
      if (c == 2) chk("stg_mask_c2", 32'(mask_a), 32'hF0);
      if (c == 3) chk("stg_mask_c3", 32'(mask_a), 32'hF1);
      if (c == 5) chk("stg_mask_c5", 32'(mask_a), 32'hF1);
      if (c == 6) chk("stg_mask_c6", 32'(mask_a), 32'hF7);
      if (c == 9) chk("stg_ls_c9", 32'(ls_a), 32'd0);
      if (c == 10) begin
        chk("stg_mask_c10", 32'(mask_a), 32'hFF);
        chk("stg_ls_c10", 32'(ls_a), 32'd1);
        chk("stg_pidx_c10", 32'(pidx_a), 32'd1);
      end
      step();
    end

    // Watchdog: lane 7 never done, TIMEOUT=4
    clear();
    lane_en = 8'hFF;
    lane_done = 8'h7F;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 5; c++) step();
    chk("to_busy_c5", 32'(busy_b), 32'd1);
    chk("to_err_c5", 32'(to_b), 32'd0);
    step();
    chk("to_err_c6", 32'(to_b), 32'd1);
    chk("to_busy_c6", 32'(busy_b), 32'd0);
    chk("to_mask_c6", 32'(mask_b), 32'h7F);
    chk("to_pidx_c6", 32'(pidx_b), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("to_start_ign_err", 32'(to_b), 32'd1);
    chk("to_start_ign_ls", 32'(ls_b), 32'd0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("to_abort_err", 32'(to_b), 32'd0);
    chk("to_abort_busy", 32'(busy_b), 32'd0);

    // Completion on the last allowed WAIT cycle beats the watchdog
    clear();
    lane_done = 8'h7F;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 5; c++) step();
    lane_done = 8'hFF;
    step();
    chk("race_err", 32'(to_b), 32'd0);
    chk("race_ls", 32'(ls_b), 32'd1);
    chk("race_pidx", 32'(pidx_b), 32'd1);

    // abort with start in IDLE
    clear();
    start = 1'b1;
    abort = 1'b1;
    step();
    chk("abst_busy", 32'(busy_a), 32'd0);
    chk("abst_ls", 32'(ls_a), 32'd0);

    // abort in WAIT of pass 5, then restart
    abort = 1'b0;
    lane_done = 8'hFF;
    step();
    start = 1'b0;
    for (int c = 1; c < 12; c++) step();
    chk("ab5_pidx", 32'(pidx_a), 32'd5);
    chk("ab5_ls", 32'(ls_a), 32'd0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab5_busy", 32'(busy_a), 32'd0);
    chk("ab5_done", 32'(done_a), 32'd0);
    chk("ab5_ls_after", 32'(ls_a), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_pidx", 32'(pidx_a), 32'd0);
    chk("restart_ls", 32'(ls_a), 32'd1);

    // Async reset in WAIT of pass 3
    for (int c = 1; c < 8; c++) step();
    chk("rw_pidx", 32'(pidx_a), 32'd3);
    chk("rw_busy_pre", 32'(busy_a), 32'd1);
    rst = 1'b1;
    #1;
    chk("rw_busy", 32'(busy_a), 32'd0);
    chk("rw_pidx0", 32'(pidx_a), 32'd0);
    chk("rw_mask", 32'(mask_a), 32'd0);
    chk("rw_ls", 32'(ls_a), 32'd0);
    chk("rw_done", 32'(done_a), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("rw_idle_busy", 32'(busy_a), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
